mac_stream_engine: RTL



---
 rtl/mac_stream_engine.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mac_stream_engine.sv
// MAC stream engine: multiplies packed signed 16-bit operand pairs from stream a, accumulates, emits one sum on d.
// Define MAC_STREAM_ENGINE_SAT_EN for saturating accumulation; the default build wraps modulo 2^32.
module mac_stream_engine #(
  parameter int unsigned CNT_LEN = 1024,
  localparam int unsigned CW = $clog2(CNT_LEN) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          test_mode_i,
  input  logic [31:0]   a_data_i,
  input  logic [3:0]    a_strb_i,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  output logic [31:0]   d_data_o,
  output logic [3:0]    d_strb_o,
  output logic          d_valid_o,
  input  logic          d_ready_i,
  input  logic          ctrl_clear_i,
  input  logic          ctrl_enable_i,
  input  logic          ctrl_start_i,
  input  logic [CW-1:0] ctrl_len_i,
  output logic [CW-1:0] flags_cnt_out_o,
  output logic          flags_mat_valid_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t        state;
  logic [31:0]   acc;
  logic [31:0]   acc_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] len_q;
  logic          d_valid;
  logic          mat_valid;
  logic [31:0]   op_x;
  logic [31:0]   op_y;
  logic [31:0]   prod;
  logic          unused;

  assign unused = ^{test_mode_i, a_strb_i};

  // Both operands fit in 16 bits, so the 32-bit product can never overflow.
  assign op_x = {{16{a_data_i[31]}}, a_data_i[31:16]};
  assign op_y = {{16{a_data_i[15]}}, a_data_i[15:0]};
  assign prod = op_x * op_y;

`ifdef MAC_STREAM_ENGINE_SAT_EN
  logic [32:0] sum_ext;
  assign sum_ext = {acc[31], acc} + {prod[31], prod};
  always_comb begin
    acc_next = sum_ext[31:0];
    if (sum_ext[32] != sum_ext[31]) begin
      acc_next = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  assign acc_next = acc + prod;
`endif

  assign cnt_next  = cnt + CW'(1);
  assign a_ready_o = (state == ACCUM) && ctrl_enable_i;

  assign d_data_o          = acc;
  assign d_strb_o          = 4'hF;
  assign d_valid_o         = d_valid;
  assign flags_cnt_out_o   = cnt;
  assign flags_mat_valid_o = mat_valid;

  // Clear beats every other input and may abandon a result still waiting on d.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      d_valid   <= 1'b0;
      mat_valid <= 1'b0;
    end else begin
      mat_valid <= 1'b0;
      if (ctrl_clear_i) begin
        state   <= IDLE;
        acc     <= '0;
        cnt     <= '0;
        d_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ctrl_start_i && (ctrl_len_i != '0)) begin
              len_q <= ctrl_len_i;
              acc   <= '0;
              cnt   <= '0;
              state <= ACCUM;
            end
          end
          ACCUM: begin
            if (a_valid_i && a_ready_o) begin
              acc <= acc_next;
              cnt <= cnt_next;
              if (cnt_next == len_q) begin
                state   <= OUTPUT;
                d_valid <= 1'b1;
              end
            end
          end
          OUTPUT: begin
            // The result handshake completes even while the engine is disabled.
            if (d_ready_i) begin
              d_valid   <= 1'b0;
              mat_valid <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
